l2_mcu_rd_tracker: RTL

- Synthesizable per-bank checker for the L2T-to-MCU read protocol. It tracks every outstanding read request from issue through ack to final data chunk, and flags protocol violations.
- One instance sits beside each L2 bank's MCU read interface and taps the same signals as the existing L2 protocol monitor.
- It generalises the monitor from passive signal taps to stateful checking: configurable ID space, chunk count and timeout, with error reporting and transaction counters.

---
 rtl/l2_mcu_rd_tracker.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/l2_mcu_rd_tracker.sv
// Per-bank checker for the L2T-to-MCU read protocol: tracks each outstanding read ID from
// request through ack to the last data chunk, reports violations and counts completions.
module l2_mcu_rd_tracker #(
   parameter int unsigned ID_W        = 3,
   parameter int unsigned ADDR_W      = 33,
   parameter int unsigned CHUNKS      = 4,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned CNT_W       = 16,
   localparam int unsigned CHUNK_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
   input  logic               l2clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               rd_req,
   input  logic [ID_W-1:0]    rd_req_id,
   input  logic [ADDR_W-1:0]  rd_addr,
   input  logic               rd_ack,
   input  logic               data_vld,
   input  logic [ID_W-1:0]    rtn_id,
   input  logic [CHUNK_W-1:0] chunk_id,
   output logic               err_valid,
   output logic [2:0]         err_code,
   output logic [ID_W-1:0]    err_id,
   output logic [ADDR_W-1:0]  err_addr,
   output logic [4:0]         err_sticky,
   output logic [ID_W:0]      outstanding,
   output logic [CNT_W-1:0]   completed_cnt
);

   localparam int unsigned NUM_IDS = 1 << ID_W;
   localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StReq, StAcked, StData} ent_state_e;

   ent_state_e         state_q  [NUM_IDS];
   logic [ADDR_W-1:0]  addr_q   [NUM_IDS];
   logic [TMR_W-1:0]   timer_q  [NUM_IDS];
   logic [CHUNK_W-1:0] exp_q    [NUM_IDS];
   logic [ID_W-1:0]    fifo_q   [NUM_IDS];
   logic [ID_W-1:0]    fifo_d   [NUM_IDS];
   logic [ID_W:0]      fifo_cnt_q, fifo_cnt_d;

   logic [NUM_IDS-1:0] req_hit, tmo, tmo_free, data_hit, ack_hit, done;
   logic               push, pop;
   logic               e_dup, e_ack, e_unexp, e_order, e_tmo;
   logic [ID_W-1:0]    tmo_id;
   logic               err_valid_d;
   logic [2:0]         err_code_d;
   logic [ID_W-1:0]    err_id_d;
   logic [ADDR_W-1:0]  err_addr_d;

   assign pop  = enable && rd_ack && (fifo_cnt_q != '0);
   assign push = enable && rd_req && (state_q[rd_req_id] == StIdle);

   always_comb begin
      for (int i = 0; i < NUM_IDS; i++) begin
         req_hit[i]  = enable && rd_req && (rd_req_id == ID_W'(i));
         tmo[i]      = enable && (state_q[i] != StIdle) && (timer_q[i] == TMR_W'(TIMEOUT_CYC));
         // A same-cycle request re-initialises the entry instead of freeing it
         tmo_free[i] = tmo[i] && !req_hit[i];
         data_hit[i] = enable && data_vld && (rtn_id == ID_W'(i));
         ack_hit[i]  = pop && (fifo_q[0] == ID_W'(i)) && (state_q[i] == StReq);
         done[i]     = data_hit[i] && !req_hit[i] && !tmo_free[i] &&
                       (((state_q[i] == StAcked) && (chunk_id == '0) && (CHUNKS == 1)) ||
                        ((state_q[i] == StData) && (chunk_id == exp_q[i]) &&
                         (exp_q[i] == CHUNK_W'(CHUNKS - 1))));
      end
   end

   // Ack FIFO: drop the popped head and any timed-out IDs, compact, then append the push
   always_comb begin
      logic [ID_W:0] wr;
      wr = '0;
      for (int i = 0; i < NUM_IDS; i++) fifo_d[i] = fifo_q[i];
      for (int i = 0; i < NUM_IDS; i++) begin
         if (((ID_W+1)'(i) < fifo_cnt_q) && !(pop && (i == 0)) && !tmo_free[fifo_q[i]]) begin
            fifo_d[wr[ID_W-1:0]] = fifo_q[i];
            wr = wr + 1'b1;
         end
      end
      if (push) begin
         fifo_d[wr[ID_W-1:0]] = rd_req_id;
         wr = wr + 1'b1;
      end
      fifo_cnt_d = wr;
   end

   always_comb begin
      e_dup   = enable && rd_req && (state_q[rd_req_id] != StIdle);
      e_ack   = enable && rd_ack && (fifo_cnt_q == '0);
      e_unexp = enable && data_vld &&
                ((state_q[rtn_id] == StIdle) || (state_q[rtn_id] == StReq));
      e_order = enable && data_vld &&
                (((state_q[rtn_id] == StAcked) && (chunk_id != '0)) ||
                 ((state_q[rtn_id] == StData) && (chunk_id != exp_q[rtn_id])));
      e_tmo   = |tmo;
      tmo_id  = '0;
      for (int i = NUM_IDS - 1; i >= 0; i--) begin
         if (tmo[i]) tmo_id = ID_W'(i);
      end

      err_valid_d = e_dup || e_ack || e_unexp || e_order || e_tmo;
      err_code_d  = 3'd0;
      err_id_d    = '0;
      err_addr_d  = '0;
      if (e_dup) begin
         err_code_d = 3'd1;
         err_id_d   = rd_req_id;
         err_addr_d = addr_q[rd_req_id];
      end else if (e_ack) begin
         err_code_d = 3'd2;
      end else if (e_unexp || e_order) begin
         err_code_d = e_unexp ? 3'd3 : 3'd4;
         err_id_d   = rtn_id;
         err_addr_d = addr_q[rtn_id];
      end else if (e_tmo) begin
         err_code_d = 3'd5;
         err_id_d   = tmo_id;
         err_addr_d = addr_q[tmo_id];
      end
   end

   always_comb begin
      outstanding = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         if (state_q[i] != StIdle) outstanding = outstanding + 1'b1;
      end
   end

   always_ff @(posedge l2clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_IDS; i++) begin
            state_q[i] <= StIdle;
            addr_q[i]  <= '0;
            timer_q[i] <= '0;
            exp_q[i]   <= '0;
            fifo_q[i]  <= '0;
         end
         fifo_cnt_q    <= '0;
         err_valid     <= 1'b0;
         err_code      <= 3'd0;
         err_id        <= '0;
         err_addr      <= '0;
         err_sticky    <= 5'd0;
         completed_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_IDS; i++) begin
            if (req_hit[i]) begin
               state_q[i] <= StReq;
               addr_q[i]  <= rd_addr;
               timer_q[i] <= '0;
            end else if (tmo_free[i]) begin
               state_q[i] <= StIdle;
               timer_q[i] <= '0;
            end else begin
               if (enable && (state_q[i] != StIdle)) timer_q[i] <= timer_q[i] + 1'b1;
               case (state_q[i])
                  StReq: begin
                     if (ack_hit[i]) state_q[i] <= StAcked;
                  end
                  StAcked: begin
                     if (data_hit[i]) begin
                        if ((chunk_id != '0) || (CHUNKS == 1)) begin
                           state_q[i] <= StIdle;
                        end else begin
                           state_q[i] <= StData;
                           exp_q[i]   <= CHUNK_W'(1);
                        end
                     end
                  end
                  StData: begin
                     if (data_hit[i]) begin
                        if ((chunk_id != exp_q[i]) || (exp_q[i] == CHUNK_W'(CHUNKS - 1))) begin
                           state_q[i] <= StIdle;
                        end else begin
                           exp_q[i] <= exp_q[i] + 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
            fifo_q[i] <= fifo_d[i];
         end
         fifo_cnt_q <= fifo_cnt_d;
         err_valid  <= err_valid_d;
         err_code   <= err_code_d;
         err_id     <= err_id_d;
         err_addr   <= err_addr_d;
         err_sticky <= err_sticky | {e_tmo, e_order, e_unexp, e_ack, e_dup};
         if ((|done) && (completed_cnt != '1)) completed_cnt <= completed_cnt + 1'b1;
      end
   end

endmodule
